// File: rtl/square_wave_gen.sv
// Square-wave generator with a valid/ready period load, boundary-aligned period
// changes, a graceful stop at the end of the running period, and a lock indicator.
module square_wave_gen #(
   parameter int COUNTER_WIDTH = 18,
   parameter int MIN_PERIOD    = 2,
   parameter int STABLE_CYCLES = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     enable,
   input  logic [COUNTER_WIDTH-1:0] period_in,
   input  logic                     period_valid,
   output logic                     period_ready,
   output logic                     signal_out,
   output logic                     edge_pulse,
   output logic [COUNTER_WIDTH-1:0] period,
   output logic                     locked
);

   localparam int LW = $clog2(STABLE_CYCLES + 1);
   localparam logic [COUNTER_WIDTH-1:0] MIN_P   = COUNTER_WIDTH'(MIN_PERIOD);
   localparam logic [LW-1:0]            LOCK_MAX = LW'(STABLE_CYCLES);

   typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

   state_t                   state, state_next;
   logic [COUNTER_WIDTH-1:0] cnt, cnt_next;
   logic [COUNTER_WIDTH-1:0] pending, period_next;
   logic [COUNTER_WIDTH-1:0] high_len, clamped;
   logic                     pend_flag, pend_clear;
   logic                     signal_next, edge_next;
   logic [LW-1:0]            lock_cnt, lock_next;
   logic                     boundary, accept;

   assign accept       = period_valid && !pend_flag;
   assign period_ready = !pend_flag;
   assign clamped      = (period_in < MIN_P) ? MIN_P : period_in;
   assign high_len     = period - (period >> 1);
   assign boundary     = (state != IDLE) && (cnt == period - COUNTER_WIDTH'(1));
   assign locked       = (lock_cnt == LOCK_MAX);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   // STOP only falls back to IDLE once the period in flight has completed.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (enable && period != '0) state_next = RUN;
         RUN:     if (!enable) state_next = STOP;
         STOP:    if (enable) state_next = RUN;
                  else if (boundary) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      cnt_next    = cnt;
      signal_next = signal_out;
      edge_next   = 1'b0;
      period_next = period;
      pend_clear  = 1'b0;
      lock_next   = lock_cnt;
      if (state == IDLE) begin
         cnt_next    = '0;
         signal_next = 1'b0;
         lock_next   = '0;
         if (pend_flag) begin
            period_next = pending;
            pend_clear  = 1'b1;
         end
         if (state_next == RUN) begin
            signal_next = 1'b1;
            edge_next   = 1'b1;
         end
      end else if (boundary) begin
         // A pending period only ever lands here, so every period is whole.
         cnt_next = '0;
         if (pend_flag) begin
            period_next = pending;
            pend_clear  = 1'b1;
            lock_next   = '0;
         end else if (lock_cnt != LOCK_MAX) begin
            lock_next = lock_cnt + LW'(1);
         end
         if (state_next == IDLE) begin
            signal_next = 1'b0;
            lock_next   = '0;
         end else begin
            signal_next = 1'b1;
            edge_next   = 1'b1;
         end
      end else begin
         cnt_next    = cnt + COUNTER_WIDTH'(1);
         signal_next = ((cnt + COUNTER_WIDTH'(1)) < high_len);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt        <= '0;
         period     <= '0;
         pending    <= '0;
         pend_flag  <= 1'b0;
         signal_out <= 1'b0;
         edge_pulse <= 1'b0;
         lock_cnt   <= '0;
      end else begin
         cnt        <= cnt_next;
         period     <= period_next;
         signal_out <= signal_next;
         edge_pulse <= edge_next;
         lock_cnt   <= lock_next;
         if (accept) begin
            pending   <= clamped;
            pend_flag <= 1'b1;
         end else if (pend_clear) begin
            pend_flag <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_square_wave_gen.sv
// Directed bench for square_wave_gen: a vector table for load/odd/minimum periods,
// then hand-written sequences for lock, mid-period and boundary changes, stop and reset.
module tb_square_wave_gen;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        enable = 1'b0;
   logic [17:0] period_in = '0;
   logic        period_valid = 1'b0;
   logic        period_ready;
   logic        signal_out;
   logic        edge_pulse;
   logic [17:0] period;
   logic        locked;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        en;
      logic        vld;
      logic [17:0] pin;
      logic        sig;
      logic        edg;
      logic [17:0] per;
      logic        rdy;
      logic        lck;
   } vec_t;

   vec_t vecs[16];

   square_wave_gen #(.COUNTER_WIDTH(18), .MIN_PERIOD(2), .STABLE_CYCLES(4)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .enable(enable),
      .period_in(period_in),
      .period_valid(period_valid),
      .period_ready(period_ready),
      .signal_out(signal_out),
      .edge_pulse(edge_pulse),
      .period(period),
      .locked(locked)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_output(input string name, input logic s, input logic e,
                               input logic [17:0] p, input logic r, input logic l);
      checks++;
      if ({signal_out, edge_pulse, period, period_ready, locked} !== {s, e, p, r, l}) begin
         errors++;
         $display("[TB] FAIL %s: got sig=%b edge=%b period=%0d ready=%b locked=%b, want sig=%b edge=%b period=%0d ready=%b locked=%b",
                  name, signal_out, edge_pulse, period, period_ready, locked, s, e, p, r, l);
      end
   endtask

   task automatic apply_stimulus(input logic en, input logic vld, input logic [17:0] pin);
      enable       = en;
      period_valid = vld;
      period_in    = pin;
   endtask

   task automatic load_period(input logic [17:0] pin);
      apply_stimulus(enable, 1'b1, pin);
      step();
      apply_stimulus(enable, 1'b0, '0);
      step();
   endtask

   // Expected waveform from position in the period; lock counts clean boundaries.
   task automatic check_run(input string name, input int n, input int p, input int phase0,
                            input int lc0, input logic rdy);
      int lc;
      int pos;
      lc = lc0;
      for (int i = 0; i < n; i++) begin
         pos = (phase0 + i) % p;
         if (i > 0 && pos == 0) lc++;
         step();
         check_output(name, pos < (p - p / 2), pos == 0, 18'(p), rdy, lc >= 4);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      apply_stimulus(1'b0, 1'b0, '0);
      step();
      step();
      rst_n = 1'b1;
   endtask

   initial begin
      vecs[0]  = '{1'b0, 1'b1, 18'd5, 1'b0, 1'b0, 18'd0, 1'b0, 1'b0};
      vecs[1]  = '{1'b0, 1'b0, 18'd0, 1'b0, 1'b0, 18'd5, 1'b1, 1'b0};
      vecs[2]  = '{1'b1, 1'b0, 18'd0, 1'b1, 1'b1, 18'd5, 1'b1, 1'b0};
      vecs[3]  = '{1'b1, 1'b0, 18'd0, 1'b1, 1'b0, 18'd5, 1'b1, 1'b0};
      vecs[4]  = '{1'b1, 1'b0, 18'd0, 1'b1, 1'b0, 18'd5, 1'b1, 1'b0};
      vecs[5]  = '{1'b1, 1'b0, 18'd0, 1'b0, 1'b0, 18'd5, 1'b1, 1'b0};
      vecs[6]  = '{1'b1, 1'b0, 18'd0, 1'b0, 1'b0, 18'd5, 1'b1, 1'b0};
      vecs[7]  = '{1'b1, 1'b0, 18'd0, 1'b1, 1'b1, 18'd5, 1'b1, 1'b0};
      vecs[8]  = '{1'b1, 1'b1, 18'd1, 1'b1, 1'b0, 18'd5, 1'b0, 1'b0};
      vecs[9]  = '{1'b1, 1'b0, 18'd0, 1'b1, 1'b0, 18'd5, 1'b0, 1'b0};
      vecs[10] = '{1'b1, 1'b0, 18'd0, 1'b0, 1'b0, 18'd5, 1'b0, 1'b0};
      vecs[11] = '{1'b1, 1'b0, 18'd0, 1'b0, 1'b0, 18'd5, 1'b0, 1'b0};
      vecs[12] = '{1'b1, 1'b0, 18'd0, 1'b1, 1'b1, 18'd2, 1'b1, 1'b0};
      vecs[13] = '{1'b1, 1'b0, 18'd0, 1'b0, 1'b0, 18'd2, 1'b1, 1'b0};
      vecs[14] = '{1'b1, 1'b0, 18'd0, 1'b1, 1'b1, 18'd2, 1'b1, 1'b0};
      vecs[15] = '{1'b1, 1'b0, 18'd0, 1'b0, 1'b0, 18'd2, 1'b1, 1'b0};

      #1;
      check_output("reset_state", 1'b0, 1'b0, 18'd0, 1'b1, 1'b0);
      step();
      rst_n = 1'b1;
      step();

      // Period 5 then a clamped request of 1 while running.
      for (int i = 0; i < 16; i++) begin
         apply_stimulus(vecs[i].en, vecs[i].vld, vecs[i].pin);
         step();
         check_output($sformatf("vec%0d", i), vecs[i].sig, vecs[i].edg, vecs[i].per,
                      vecs[i].rdy, vecs[i].lck);
      end

      // Period 10, lock after four complete periods.
      do_reset();
      load_period(18'd10);
      apply_stimulus(1'b1, 1'b0, '0);
      check_run("p10_lock", 50, 10, 0, 0, 1'b1);

      // Change 8 -> 12 mid-period, then a request landing on the boundary cycle.
      do_reset();
      load_period(18'd8);
      apply_stimulus(1'b1, 1'b0, '0);
      check_run("p8_run", 43, 8, 0, 0, 1'b1);
      apply_stimulus(1'b1, 1'b1, 18'd12);
      check_run("p8_accept", 1, 8, 3, 5, 1'b0);
      apply_stimulus(1'b1, 1'b0, '0);
      check_run("p8_finish", 4, 8, 4, 5, 1'b0);
      check_run("p12_run", 60, 12, 0, 0, 1'b1);
      apply_stimulus(1'b1, 1'b1, 18'd6);
      check_run("bnd_accept", 1, 12, 0, 5, 1'b0);
      apply_stimulus(1'b1, 1'b0, '0);
      check_run("bnd_oldperiod", 11, 12, 1, 5, 1'b0);
      check_run("bnd_newperiod", 12, 6, 0, 0, 1'b1);

      // Drop enable mid-high: finish the period, then idle.
      do_reset();
      load_period(18'd10);
      apply_stimulus(1'b1, 1'b0, '0);
      check_run("stop_pre", 43, 10, 0, 0, 1'b1);
      apply_stimulus(1'b0, 1'b0, '0);
      check_run("stop_finish", 7, 10, 3, 4, 1'b1);
      step();
      check_output("stop_idle", 1'b0, 1'b0, 18'd10, 1'b1, 1'b0);
      step();
      check_output("stop_idle_hold", 1'b0, 1'b0, 18'd10, 1'b1, 1'b0);

      // Re-enable during STOP gives an unbroken waveform.
      apply_stimulus(1'b1, 1'b0, '0);
      check_run("reen_run", 4, 10, 0, 0, 1'b1);
      apply_stimulus(1'b0, 1'b0, '0);
      check_run("reen_stop", 2, 10, 4, 0, 1'b1);
      apply_stimulus(1'b1, 1'b0, '0);
      check_run("reen_resume", 14, 10, 6, 0, 1'b1);
      check_run("reen_more", 3, 10, 0, 2, 1'b1);

      // Asynchronous reset mid-high-phase.
      #3;
      rst_n = 1'b0;
      #1;
      check_output("async_reset", 1'b0, 1'b0, 18'd0, 1'b1, 1'b0);
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         check_output("no_load_idle", 1'b0, 1'b0, 18'd0, 1'b1, 1'b0);
      end

      // A request of 0 clamps to the minimum period.
      apply_stimulus(1'b0, 1'b0, '0);
      load_period(18'd0);
      check_output("clamp_zero", 1'b0, 1'b0, 18'd2, 1'b1, 1'b0);
      apply_stimulus(1'b1, 1'b0, '0);
      check_run("p2_toggle", 6, 2, 0, 0, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/square_wave_gen.md
SQUARE_WAVE_GEN -- requirements
Module: square_wave_gen

Interface
REQ-001 SHALL have parameter COUNTER_WIDTH, default 18, which sets the width of the period count in clk cycles (262,143 max).
REQ-002 SHALL have parameter MIN_PERIOD, default 2, which sets the smallest period generated; smaller requests are clamped up to it.
REQ-003 SHALL have parameter STABLE_CYCLES, default 4, which sets the number of consecutive complete periods at one period value before locked asserts.
REQ-004 SHALL have port clk, input, 1 bit: the single clock, 200 MHz target.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port enable, input, 1 bit: level request to run the generator.
REQ-007 SHALL have port period_in, input, COUNTER_WIDTH bits: requested period in clk cycles.
REQ-008 SHALL have port period_valid, input, 1 bit: period_in is presented.
REQ-009 SHALL have port period_ready, output, 1 bit: the block can accept period_in.
REQ-010 SHALL have port signal_out, output, 1 bit: registered square wave.
REQ-011 SHALL have port edge_pulse, output, 1 bit: one-cycle pulse, high in the same cycle signal_out first goes high in each period.
REQ-012 SHALL have port period, output, COUNTER_WIDTH bits: the period currently in effect (active register).
REQ-013 SHALL have port locked, output, 1 bit: the output frequency is settled.

Function
REQ-014 SHALL take a period transfer on any cycle where period_valid and period_ready are both high; the value is clamped to MIN_PERIOD if smaller and written to the pending register, and the pending flag is set.
REQ-015 SHALL drive period_ready as the inverse of the pending flag; while a value is pending, further requests stall.
REQ-016 SHALL implement a three-state FSM: IDLE, RUN, STOP.
REQ-017 In IDLE, a pending value SHALL move to period on the next edge and clear the pending flag.
REQ-018 In IDLE, the FSM SHALL go to RUN when enable=1 and period!=0; enable SHALL be ignored while period==0.
REQ-019 On the edge entering RUN, the block SHALL load cnt<=0, signal_out<=1 and edge_pulse<=1.
REQ-020 In RUN/STOP, cnt SHALL count 0..P-1 where P=period; signal_out SHALL be high for H=P-(P>>1) cycles, then low for P>>1 cycles (P=5: 3 high, 2 low; P=2: 1 high, 1 low).
REQ-021 The period boundary SHALL be the cycle with cnt==P-1. On that edge in RUN: cnt wraps to 0, signal_out<=1, edge_pulse<=1, and, if the pending flag is set, period<=pending with the flag cleared.
REQ-022 Period changes SHALL take effect only at a boundary; no truncated or stretched period is ever produced.
REQ-023 A transfer accepted on the boundary cycle itself SHALL apply at the following boundary, not the current one.
REQ-024 When enable=0 in RUN, the FSM SHALL go to STOP; when enable returns to 1 in STOP, it SHALL go back to RUN with no glitch.
REQ-025 At the STOP boundary, the FSM SHALL go to IDLE with signal_out<=0 and edge_pulse<=0, and any pending value SHALL apply on that same edge.
REQ-026 locked SHALL use a saturating counter that increments at each RUN boundary with no period change, up to STABLE_CYCLES.
REQ-027 locked SHALL equal (counter==STABLE_CYCLES).
REQ-028 The locked counter SHALL clear on any period change and on entering IDLE.
REQ-029 In IDLE, the block SHALL hold signal_out=0, edge_pulse=0, locked=0 and cnt=0.
REQ-030 cnt SHALL never exceed P-1.

Reset
REQ-031 On rst_n=0 the block SHALL asynchronously force FSM=IDLE, cnt=0, period=0, pending=0, pending flag=0, signal_out=0, edge_pulse=0, locked=0; period_ready therefore reads 1.
REQ-032 Reset asserted mid-period SHALL take effect immediately, with no completion of the period; after release the block SHALL wait for a new period transfer before running.

Verification
REQ-033 Load 10 in IDLE, then enable=1 -> signal_out goes high one cycle after enable is sampled; pattern 5 high / 5 low repeats; edge_pulse fires every 10 cycles; locked=1 after 4 complete periods.
REQ-034 Odd and minimum periods: 5 -> 3 high / 2 low; a request of 0 or 1 -> period reads 2, output toggles each cycle.
REQ-035 While running at 8, request 12 mid-period -> period_ready drops; the current 8-cycle period completes; the next period is 12 (6/6); locked clears, then reasserts after 4 periods.
REQ-036 Request accepted exactly on a boundary cycle -> one more old-length period, then the new period.
REQ-037 Drop enable mid-high phase at P=10 -> the period completes, signal_out=0, IDLE, locked=0. Re-enable during STOP -> continuous output with no gap.
REQ-038 Assert rst_n=0 mid-period -> all outputs reach their reset values in the same cycle. Enable without a new load -> no output.
